// File: rtl/ifetch_unit_if.sv
// Fetch-side bundle: PC strobe, instruction-memory request/response, and the decode handshake.
// The master modport is the fetch unit; the slave modport is the PC, memory and decode around it.
interface ifetch_unit_if;
    logic [31:0] pc_addr;
    logic        pc_en;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        flush;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        err_rsp;

    modport master (
        input  pc_addr, imem_req_ready, imem_rsp_valid, imem_rsp_data, flush, inst_ready,
        output pc_en, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, err_rsp
    );

    modport slave (
        output pc_addr, imem_req_ready, imem_rsp_valid, imem_rsp_data, flush, inst_ready,
        input  pc_en, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, err_rsp
    );
endinterface

// File: rtl/ifetch_unit.sv
// Credit-limited instruction fetch: 1-cycle response-to-inst_valid latency through a registered queue;
// requests stall when queued plus in-flight entries would exceed FQ_DEPTH, decode stalls simply hold the head.
module ifetch_unit #(
    parameter int FQ_DEPTH = 2,
    parameter int MAX_OUT  = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    ifetch_unit_if.master io_bus
);
    localparam int QW = $clog2(FQ_DEPTH);
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [29:0]   r_af_mem [MAX_OUT];
    logic [AW-1:0] r_af_wr;
    logic [AW-1:0] r_af_rd;
    logic [OW-1:0] r_out;
    logic [OW-1:0] r_drop;
    logic [29:0]   r_q_pc   [FQ_DEPTH];
    logic [31:0]   r_q_dat  [FQ_DEPTH];
    logic [QW-1:0] r_q_wr;
    logic [QW-1:0] r_q_rd;
    logic [CW-1:0] r_q_cnt;
    logic          r_live;
    logic          r_err;

    logic w_req_vld;
    logic w_acc;
    logic w_rsp_pop;
    logic w_push;
    logic w_pop;
    logic w_q_nz;
    logic w_unused_pc_lo;

    function automatic logic [AW-1:0] af_next(input logic [AW-1:0] p);
        return (int'(p) == MAX_OUT - 1) ? '0 : p + 1'b1;
    endfunction

    // r_live keeps requests off for the first cycle after reset is released.
    assign w_q_nz    = (r_q_cnt != '0);
    assign w_req_vld = i_rst && r_live && !io_bus.flush && (int'(r_out) < MAX_OUT)
                       && ((int'(r_q_cnt) + int'(r_out)) < FQ_DEPTH);
    assign w_acc     = w_req_vld && io_bus.imem_req_ready;
    assign w_rsp_pop = io_bus.imem_rsp_valid && (r_out != '0);
    assign w_push    = w_rsp_pop && (r_drop == '0) && !io_bus.flush;
    assign w_pop     = io_bus.inst_valid && io_bus.inst_ready;
    assign w_unused_pc_lo = ^io_bus.pc_addr[1:0];

    assign io_bus.pc_en          = w_acc;
    assign io_bus.imem_req_valid = w_req_vld;
    assign io_bus.imem_req_addr  = {io_bus.pc_addr[31:2], 2'b00};
    assign io_bus.inst_valid     = i_rst && w_q_nz && !io_bus.flush;
    assign io_bus.inst_data      = w_q_nz ? r_q_dat[r_q_rd] : '0;
    assign io_bus.inst_pc        = w_q_nz ? {r_q_pc[r_q_rd], 2'b00} : '0;
    assign io_bus.err_rsp        = r_err;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_af_wr <= '0;
            r_af_rd <= '0;
            r_out   <= '0;
            r_drop  <= '0;
            r_q_wr  <= '0;
            r_q_rd  <= '0;
            r_q_cnt <= '0;
            r_live  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_acc) begin
                r_af_mem[r_af_wr] <= io_bus.pc_addr[31:2];
                r_af_wr           <= af_next(r_af_wr);
            end
            if (w_rsp_pop) begin
                r_af_rd <= af_next(r_af_rd);
            end
            if (io_bus.imem_rsp_valid && (r_out == '0)) begin
                r_err <= 1'b1;
            end
            case ({w_acc, w_rsp_pop})
                2'b10:   r_out <= r_out + 1'b1;
                2'b01:   r_out <= r_out - 1'b1;
                default: r_out <= r_out;
            endcase
            // Flush: every response still owed is stale, including none accepted this cycle.
            if (io_bus.flush) begin
                r_drop  <= w_rsp_pop ? r_out - 1'b1 : r_out;
                r_q_wr  <= '0;
                r_q_rd  <= '0;
                r_q_cnt <= '0;
            end else begin
                if (w_rsp_pop && (r_drop != '0)) begin
                    r_drop <= r_drop - 1'b1;
                end
                if (w_push) begin
                    r_q_pc[r_q_wr]  <= r_af_mem[r_af_rd];
                    r_q_dat[r_q_wr] <= io_bus.imem_rsp_data;
                    r_q_wr          <= r_q_wr + 1'b1;
                end
                if (w_pop) begin
                    r_q_rd <= r_q_rd + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_q_cnt <= r_q_cnt + 1'b1;
                    2'b01:   r_q_cnt <= r_q_cnt - 1'b1;
                    default: r_q_cnt <= r_q_cnt;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench: a PC/memory/decode environment drives ifetch_unit while a scoreboard of
// expected instructions is checked by an independent monitor on the decode port.
module tb_ifetch_unit;
    localparam int FQ_DEPTH = 2;
    localparam int MAX_OUT  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ifetch_unit_if bus();

    ifetch_unit #(.FQ_DEPTH(FQ_DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    // In-flight request: address plus the flush epoch it was issued in.
    typedef struct { logic [31:0] addr; int epoch; int cyc; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] dat; } ex_t;

    fl_t inflight[$];
    ex_t exp_q[$];

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          epoch     = 0;
    int          delivered = 0;
    int          n_flush   = 0;
    bit          err_exp   = 1'b0;
    bit          rst_hold  = 1'b0;
    logic [31:0] pc        = 32'h0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Phase stimulus as percentages: req_ready, inst_ready, response, flush, reset, unsolicited response.
    task automatic run(input int n, input int p_rdy, input int p_irdy, input int p_rsp,
                       input int p_flush, input int p_rst, input int p_bogus);
        bit  gate;
        bit  e_rv;
        bit  acc;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            cyc++;
            rst = ($urandom_range(0, 99) < p_rst) ? 1'b0 : 1'b1;
            bus.flush = ($urandom_range(0, 99) < p_flush) ? 1'b1 : 1'b0;
            if (bus.flush) begin
                pc = (n_flush == 0) ? 32'h100 : 32'($urandom_range(0, 4095)) << 2;
                n_flush++;
            end
            bus.pc_addr        = pc | 32'($urandom_range(0, 3));
            bus.imem_req_ready = ($urandom_range(0, 99) < p_rdy);
            bus.inst_ready     = ($urandom_range(0, 99) < p_irdy);
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
            if (inflight.size() > 0) begin
                if (inflight[0].cyc < cyc && $urandom_range(0, 99) < p_rsp) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = memf(inflight[0].addr);
                end
            end else if ($urandom_range(0, 99) < p_bogus) begin
                bus.imem_rsp_valid = 1'b1;
            end

            @(negedge clk);
            gate = rst && !rst_hold;
            e_rv = gate && !bus.flush && (inflight.size() < MAX_OUT)
                   && ((exp_q.size() + inflight.size()) < FQ_DEPTH);
            chk("req_valid", bus.imem_req_valid, e_rv);
            chk("pc_en", bus.pc_en, e_rv && bus.imem_req_ready);
            if (e_rv) chk("req_addr", bus.imem_req_addr, pc);
            chk("inst_valid", bus.inst_valid, gate && !bus.flush && (exp_q.size() != 0));
            chk("err_rsp", bus.err_rsp, err_exp);
            if (rst && rst_hold) begin
                chk("rst_inst_pc", bus.inst_pc, 32'h0);
                chk("rst_inst_data", bus.inst_data, 32'h0);
            end
            acc = bus.imem_req_valid && bus.imem_req_ready;

            // Let the monitor consume this cycle's pop before the model advances.
            #2;
            if (!rst) begin
                inflight.delete();
                exp_q.delete();
                err_exp = 1'b0;
            end else begin
                if (bus.imem_rsp_valid) begin
                    if (inflight.size() == 0) begin
                        err_exp = 1'b1;
                    end else begin
                        fl_t e;
                        e = inflight.pop_front();
                        if (!bus.flush && e.epoch == epoch)
                            exp_q.push_back('{pc: e.addr, dat: bus.imem_rsp_data});
                    end
                end
                if (bus.flush) begin
                    exp_q.delete();
                    epoch++;
                end
                if (acc) begin
                    inflight.push_back('{addr: pc, epoch: epoch, cyc: cyc});
                    pc = pc + 32'd4;
                end
            end
            rst_hold = !rst;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (bus.inst_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL inst_unexpected: got inst_pc 0x%08h expected no instruction at cycle %0d",
                             bus.inst_pc, cyc);
                end else begin
                    chk("inst_pc", bus.inst_pc, exp_q[0].pc);
                    chk("inst_data", bus.inst_data, exp_q[0].dat);
                    if (bus.inst_ready) begin
                        void'(exp_q.pop_front());
                        delivered++;
                    end
                end
            end
        end
    end

    initial begin
        bus.pc_addr        = 32'h0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.flush          = 1'b0;
        bus.inst_ready     = 1'b0;
        rst                = 1'b0;

        run(3,    0,   0,   0,  0, 100,   0);   // reset
        run(60,   100, 100, 100, 0, 0,    0);   // streaming, 1-cycle memory
        run(20,   100, 0,   100, 0, 0,    0);   // decode backpressure
        run(20,   100, 100, 100, 0, 0,    0);   // release
        run(300,  100, 50,  70, 10, 0,    0);   // flushes against full queue
        run(8,    0,   100, 100, 0, 0,    0);   // drain
        run(3,    0,   100, 100, 0, 0,  100);   // unsolicited responses
        run(2,    0,   100, 100, 0, 0,    0);   // error stays set
        run(1,    0,   100, 100, 0, 100,  0);   // reset clears error
        run(1500, 70,  60,  60,  4, 1,    1);   // mixed random traffic

        for (int k = 0; k < 50 && (inflight.size() != 0 || exp_q.size() != 0); k++)
            run(1, 0, 100, 100, 0, 0, 0);
        chk("drain_inflight", 32'(inflight.size()), 32'h0);
        chk("drain_queue", 32'(exp_q.size()), 32'h0);
        chk("delivered_min", 32'(delivered >= 100), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter FQ_DEPTH, default 2: fetch queue entries, power of two, 2..8.
REQ-002 Parameter MAX_OUT, default 2: maximum in-flight imem requests, 1..FQ_DEPTH.
REQ-003 clk  in  1  single system clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-low (rst==0 resets on posedge clk).
REQ-005 pc_addr  in  32  current fetch address from the program counter register.
REQ-006 pc_en  out  1  advance strobe to the program counter register (its enable).
REQ-007 imem_req_valid  out  1  instruction-memory request valid.
REQ-008 imem_req_ready  in  1  memory accepts request this cycle.
REQ-009 imem_req_addr  out  32  request address, {pc_addr[31:2],2'b00}.
REQ-010 imem_rsp_valid  in  1  in-order response strobe; no backpressure.
REQ-011 imem_rsp_data  in  32  instruction word, valid with imem_rsp_valid.
REQ-012 flush  in  1  redirect: discard all fetched and in-flight instructions.
REQ-013 inst_valid  out  1  instruction available to decode.
REQ-014 inst_ready  in  1  decode consumes instruction this cycle.
REQ-015 inst_data  out  32  instruction word of queue head.
REQ-016 inst_pc  out  32  word-aligned address of queue head.
REQ-017 err_rsp  out  1  sticky flag: response received with nothing in flight.

Function
REQ-018 imem_req_valid SHALL be 1 iff flush==0, outstanding<MAX_OUT and (q_count+outstanding)<FQ_DEPTH (credit rule; responses can never overflow the queue).
REQ-019 Request accepted when imem_req_valid&&imem_req_ready; pc_en SHALL equal exactly that term, combinationally, same cycle.
REQ-020 On accept the request address SHALL be pushed into an in-flight address FIFO of depth MAX_OUT and outstanding incremented.
REQ-021 On imem_rsp_valid with outstanding>0: pop address FIFO, decrement outstanding; accept+response same cycle leaves outstanding unchanged.
REQ-022 Popped response SHALL be pushed as {addr,data} into the fetch queue unless drop_cnt>0, in which case it is discarded and drop_cnt decremented.
REQ-023 Responses SHALL be delivered to decode in issue order; latency response-to-inst_valid is 1 cycle (queue registered).
REQ-024 inst_valid SHALL be (q_count!=0)&&(flush==0); inst_data/inst_pc SHALL hold stable while inst_valid&&!inst_ready.
REQ-025 Pop on inst_valid&&inst_ready; simultaneous push and pop SHALL keep q_count unchanged, including at q_count==FQ_DEPTH-1 and q_count==1.
REQ-026 Queue read/write pointers SHALL wrap modulo FQ_DEPTH without loss.
REQ-027 On flush: queue emptied next cycle, no request issued, no pop, drop_cnt <= outstanding minus 1 if imem_rsp_valid that cycle (that response discarded); address FIFO entries retained for tag pops.
REQ-028 Flush while drop_cnt>0 SHALL recompute drop_cnt per REQ-027; back-to-back flushes legal.
REQ-029 imem_rsp_valid with outstanding==0 SHALL be ignored (no push, no pop) and set err_rsp until reset.
REQ-030 pc_addr[1:0] SHALL be ignored; misalignment is not detected here.

Reset
REQ-031 rst==0 at posedge clk SHALL clear q_count, pointers, outstanding, drop_cnt, err_rsp; inst_data, inst_pc SHALL read 0.
REQ-032 During and one cycle after reset, imem_req_valid, pc_en, inst_valid SHALL be 0; reset overrides flush and all handshakes, mid-operation included; responses to pre-reset requests are the environment's responsibility.

Verification
REQ-033 Stream: pc_addr 0,4,8,... from PC, req_ready=1, 1-cycle response latency, inst_ready=1 -> inst_pc 0x0,0x4,0x8 in order, inst_data matches memory, pc_en once per accept.
REQ-034 Backpressure: inst_ready=0 with FQ_DEPTH=2, MAX_OUT=2 -> after 2 accepts imem_req_valid=0, q fills to 2, inst_data stable; release inst_ready -> requests resume one per freed credit.
REQ-035 Flush with 2 in flight and 1 queued: flush one cycle at pc_addr 0x100 -> inst_valid 0 next cycle, both stale responses dropped, first delivered inst_pc=0x100.
REQ-036 Flush coincident with response and push/pop at full -> that response discarded, drop_cnt=outstanding-1, no lost or duplicated instruction afterwards.
REQ-037 Unsolicited imem_rsp_valid after reset -> err_rsp=1, queue empty; rst=0 one cycle -> err_rsp=0.
REQ-038 rst=0 mid-stream with q_count=2 -> next cycle all valid outputs 0, q empty, outstanding 0.
